// File: rtl/receptor_serie.sv
`default_nettype none
// ============================================================================
// Module   : receptor_serie
// Purpose  : Serial-to-parallel receiver at the far end of the bitHolder
//            shift-register chain. Reassembles N serial bits into a word,
//            in either shift direction, and hands it out through a
//            valid/ack handshake with a sticky overrun flag.
// Options  : RECEPTOR_PARIDAD_EN - when defined, each frame carries one
//            trailing even-parity bit that is checked into err_paridad.
//            When undefined, err_paridad is tied to 0.
// Ports    : clk         rising-edge clock
//            reset       asynchronous active-high reset
//            inicio      frame start request (ESPERA, or LISTO with ack)
//            enb         serial bit strobe
//            dir         0 = shift left (first bit -> MSB), 1 = shift right
//            s_in        serial data bit
//            ack         consumer acknowledge of q
//            q           last completed word
//            q_valid     q holds an unacknowledged word
//            ocupado     receiver is not idle
//            desborde    sticky overrun flag
//            err_paridad parity error of the last frame
// Revision : 1.0 - initial release
// ============================================================================
module receptor_serie #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic         enb,
  input  logic         dir,
  input  logic         s_in,
  input  logic         ack,
  output logic [N-1:0] q,
  output logic         q_valid,
  output logic         ocupado,
  output logic         desborde,
  output logic         err_paridad
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] c_ULT = CW'(N - 1);

  localparam logic [1:0] ESPERA  = 2'd0;
  localparam logic [1:0] CARGA   = 2'd1;
  localparam logic [1:0] LISTO   = 2'd2;
  localparam logic [1:0] PARIDAD = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  w_sr_shift;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic [N-1:0]  r_q;
  logic          r_q_valid;
  logic          r_desborde;
  logic          w_ultimo;
  logic          w_arranque;

  // Shifted value including the bit arriving on this edge; also what q
  // captures on the last data bit so q_valid has no extra cycle of latency.
  assign w_sr_shift = r_dir ? {s_in, r_sr[N-1:1]} : {r_sr[N-2:0], s_in};
  assign w_ultimo   = enb && (r_cnt == c_ULT);

  // A new frame may start from idle, or straight from LISTO when the
  // consumer acknowledges and requests the next frame on the same edge.
  assign w_arranque = inicio && ((r_state == ESPERA) || ((r_state == LISTO) && ack));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ESPERA;
    else       r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ESPERA: if (inicio) w_next_state = CARGA;
      CARGA: begin
        if (w_ultimo) begin
`ifdef RECEPTOR_PARIDAD_EN
          w_next_state = PARIDAD;
`else
          w_next_state = LISTO;
`endif
        end
      end
`ifdef RECEPTOR_PARIDAD_EN
      PARIDAD: if (enb) w_next_state = LISTO;
`endif
      LISTO: if (ack) w_next_state = inicio ? CARGA : ESPERA;
      default: w_next_state = ESPERA;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    ocupado = (r_state != ESPERA);
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, bit counter, word and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_desborde <= 1'b0;
    end else begin
      if (w_arranque) begin
        r_sr  <= '0;
        r_cnt <= '0;
        r_dir <= dir;
      end else if ((r_state == CARGA) && enb) begin
        r_sr  <= w_sr_shift;
        r_cnt <= r_cnt + CW'(1);
      end

`ifndef RECEPTOR_PARIDAD_EN
      if ((r_state == CARGA) && w_ultimo) begin
        r_q       <= w_sr_shift;
        r_q_valid <= 1'b1;
      end
`else
      // With parity the word is published only once the parity bit lands.
      if ((r_state == PARIDAD) && enb) begin
        r_q       <= r_sr;
        r_q_valid <= 1'b1;
      end
`endif

      if (r_state == LISTO) begin
        if (ack)      r_q_valid  <= 1'b0;
        else if (enb) r_desborde <= 1'b1;  // bit dropped while word unread
      end
    end
  end

`ifdef RECEPTOR_PARIDAD_EN
  logic r_err_paridad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_paridad <= 1'b0;
    end else if (w_arranque) begin
      r_err_paridad <= 1'b0;
    end else if ((r_state == PARIDAD) && enb) begin
      r_err_paridad <= (^r_sr) ^ s_in;  // even parity: 0 means consistent
    end
  end

  assign err_paridad = r_err_paridad;
`else
  assign err_paridad = 1'b0;
`endif

  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign desborde = r_desborde;

endmodule
`default_nettype wire

// File: tb/tb_receptor_serie.sv
`default_nettype none
// ============================================================================
// Module   : tb_receptor_serie
// Purpose  : Directed self-checking bench for receptor_serie (N = 4).
//            Inputs change 1 ns after the rising edge; outputs are sampled
//            at that same point, once the edge has settled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receptor_serie;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic       enb = 1'b0;
  logic       dir = 1'b0;
  logic       s_in = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] q;
  logic       q_valid;
  logic       ocupado;
  logic       desborde;
  logic       err_paridad;

  int n_pass  = 0;
  int n_total = 0;

  receptor_serie #(.N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .enb        (enb),
    .dir        (dir),
    .s_in       (s_in),
    .ack        (ack),
    .q          (q),
    .q_valid    (q_valid),
    .ocupado    (ocupado),
    .desborde   (desborde),
    .err_paridad(err_paridad)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inicio = 1'b0; enb = 1'b0; ack = 1'b0; s_in = 1'b0; dir = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_frame(input logic d);
    inicio = 1'b1; dir = d;
    tick();
    inicio = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    enb = 1'b1; s_in = b;
    tick();
    enb = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({q, q_valid, ocupado, desborde, err_paridad} !== 8'b0)
      $display("FAIL reset_outputs: got q=%b v=%b oc=%b d=%b e=%b want all 0",
               q, q_valid, ocupado, desborde, err_paridad);
    else n_pass++;
  endtask

  task automatic test_shift_left();
    start_frame(1'b0);
    n_total++;
    if (ocupado !== 1'b1) $display("FAIL t1_ocupado_start: got %b want 1", ocupado);
    else n_pass++;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_total++;
    if (q_valid !== 1'b0) $display("FAIL t1_early_valid: got %b want 0", q_valid);
    else n_pass++;
    send_bit(1'b1);
`ifdef RECEPTOR_PARIDAD_EN
    send_bit(1'b1);
`endif
    n_total++;
    if (q_valid !== 1'b1 || q !== 4'b1011)
      $display("FAIL t1_word: got q=%b v=%b want q=1011 v=1", q, q_valid);
    else n_pass++;
    n_total++;
    if (ocupado !== 1'b1) $display("FAIL t1_ocupado_listo: got %b want 1", ocupado);
    else n_pass++;
    send_ack();
    n_total++;
    if (q_valid !== 1'b0 || ocupado !== 1'b0)
      $display("FAIL t1_ack: got v=%b oc=%b want 0 0", q_valid, ocupado);
    else n_pass++;
  endtask

  task automatic test_shift_right();
    start_frame(1'b1);
    send_word(4'b1011);
`ifdef RECEPTOR_PARIDAD_EN
    send_bit(1'b1);
`endif
    n_total++;
    if (q !== 4'b1101 || q_valid !== 1'b1)
      $display("FAIL t2_right: got q=%b v=%b want q=1101 v=1", q, q_valid);
    else n_pass++;
    send_ack();
    // dir flips mid-frame; the latched direction must win
    start_frame(1'b1);
    send_bit(1'b1);
    dir = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef RECEPTOR_PARIDAD_EN
    send_bit(1'b1);
`endif
    n_total++;
    if (q !== 4'b1101) $display("FAIL t2_dir_toggle: got q=%b want 1101", q);
    else n_pass++;
    send_ack();
  endtask

  task automatic test_gaps_and_reset();
    logic [3:0] w;
    w = 4'b0110;
    start_frame(1'b0);
    for (int i = 3; i >= 0; i--) begin
      n_total++;
      if (q_valid !== 1'b0) $display("FAIL t3_gap_valid: got %b want 0 before bit %0d", q_valid, 3 - i);
      else n_pass++;
      send_bit(w[i]);
      if (i != 0) begin
        tick(); tick(); tick();
      end
    end
`ifdef RECEPTOR_PARIDAD_EN
    send_bit(1'b0);
`endif
    n_total++;
    if (q !== 4'b0110 || q_valid !== 1'b1)
      $display("FAIL t3_word: got q=%b v=%b want q=0110 v=1", q, q_valid);
    else n_pass++;
    send_ack();
    start_frame(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    reset = 1'b1;
    #1;
    n_total++;
    if ({q, q_valid, ocupado, desborde, err_paridad} !== 8'b0)
      $display("FAIL t3_mid_reset: got q=%b v=%b oc=%b d=%b e=%b want all 0",
               q, q_valid, ocupado, desborde, err_paridad);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    start_frame(1'b0);
    send_word(4'b1011);
`ifdef RECEPTOR_PARIDAD_EN
    send_bit(1'b1);
`endif
    n_total++;
    if (desborde !== 1'b0) $display("FAIL t4_no_overrun_yet: got %b want 0", desborde);
    else n_pass++;
    send_bit(1'b1);
    n_total++;
    if (desborde !== 1'b1 || q !== 4'b1011 || q_valid !== 1'b1)
      $display("FAIL t4_overrun: got d=%b q=%b v=%b want d=1 q=1011 v=1", desborde, q, q_valid);
    else n_pass++;
    send_ack();
    n_total++;
    if (q_valid !== 1'b0 || desborde !== 1'b1)
      $display("FAIL t4_sticky: got v=%b d=%b want v=0 d=1", q_valid, desborde);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int low_cycles;
    do_reset();
    start_frame(1'b0);
    send_word(4'b1011);
`ifdef RECEPTOR_PARIDAD_EN
    send_bit(1'b1);
`endif
    // ack + inicio + enb together: restart, bit discarded, no overrun
    ack = 1'b1; inicio = 1'b1; enb = 1'b1; s_in = 1'b1; dir = 1'b0;
    tick();
    ack = 1'b0; inicio = 1'b0; enb = 1'b0;
    low_cycles = (q_valid === 1'b0) ? 1 : 0;
    n_total++;
    if (ocupado !== 1'b1 || desborde !== 1'b0)
      $display("FAIL t5_restart: got oc=%b d=%b want oc=1 d=0", ocupado, desborde);
    else n_pass++;
    send_bit(1'b0); if (q_valid === 1'b0) low_cycles++;
    send_bit(1'b0); if (q_valid === 1'b0) low_cycles++;
    send_bit(1'b0); if (q_valid === 1'b0) low_cycles++;
    send_bit(1'b1);
`ifdef RECEPTOR_PARIDAD_EN
    if (q_valid === 1'b0) low_cycles++;
    send_bit(1'b1);
    n_total++;
    if (low_cycles !== 5) $display("FAIL t5_low_cycles: got %0d want 5", low_cycles);
    else n_pass++;
`else
    n_total++;
    if (low_cycles !== 4) $display("FAIL t5_low_cycles: got %0d want 4", low_cycles);
    else n_pass++;
`endif
    n_total++;
    if (q_valid !== 1'b1 || q !== 4'b0001)
      $display("FAIL t5_word: got q=%b v=%b want q=0001 v=1", q, q_valid);
    else n_pass++;
    send_ack();
  endtask

  task automatic test_parity();
`ifdef RECEPTOR_PARIDAD_EN
    start_frame(1'b0);
    send_word(4'b1011);
    n_total++;
    if (q_valid !== 1'b0 || q !== 4'b0001)
      $display("FAIL t6_wait_parity: got q=%b v=%b want q=0001 v=0", q, q_valid);
    else n_pass++;
    send_bit(1'b1);
    n_total++;
    if (q !== 4'b1011 || q_valid !== 1'b1 || err_paridad !== 1'b0)
      $display("FAIL t6_parity_ok: got q=%b v=%b e=%b want 1011 1 0", q, q_valid, err_paridad);
    else n_pass++;
    send_ack();
    start_frame(1'b0);
    send_word(4'b1011);
    send_bit(1'b0);
    n_total++;
    if (q !== 4'b1011 || q_valid !== 1'b1 || err_paridad !== 1'b1)
      $display("FAIL t6_parity_bad: got q=%b v=%b e=%b want 1011 1 1", q, q_valid, err_paridad);
    else n_pass++;
    ack = 1'b1; inicio = 1'b1;
    tick();
    ack = 1'b0; inicio = 1'b0;
    n_total++;
    if (err_paridad !== 1'b0) $display("FAIL t6_parity_clear: got %b want 0", err_paridad);
    else n_pass++;
    do_reset();
`else
    start_frame(1'b0);
    send_word(4'b0111);
    n_total++;
    if (q !== 4'b0111 || err_paridad !== 1'b0)
      $display("FAIL t6_no_parity: got q=%b e=%b want 0111 0", q, err_paridad);
    else n_pass++;
    send_ack();
`endif
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_shift_right();
    test_gaps_and_reset();
    test_overrun();
    test_back_to_back();
    test_parity();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/receptor_serie.md
Name: receptor_serie

Overview:
Serial-to-parallel receiver that sits at the far end of the bitHolder universal shift-register chain. It consumes the serial bit stream produced by the chain in serial-load mode and reassembles it into an N-bit word. It supports both shift directions (dir), frame start/complete signalling, and a valid/ack output handshake with overrun detection.

Parameters:
N, 4, word width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
inicio  input  1  frame start request; sampled in ESPERA, or in LISTO together with ack.
enb  input  1  serial bit strobe; s_in is captured on a posedge where enb=1.
dir  input  1  0 = shift left (first bit lands in MSB); 1 = shift right (first bit lands in LSB); latched at frame start.
s_in  input  1  serial data bit.
ack  input  1  consumer acknowledge of q.
q  output  N  last completed word.
q_valid  output  1  q holds an unacknowledged word.
ocupado  output  1  high when state != ESPERA.
desborde  output  1  sticky overrun flag.
err_paridad  output  1  parity error of the last frame; tied 0 when the parity feature is compiled out.

Behaviour:
- Reset (async, active-high): state=ESPERA; internal shift register sr=0; cnt=0; dir_r=0; q=0; q_valid=0; desborde=0; err_paridad=0. Reset asserted mid-frame discards the partial word.
- States: ESPERA, CARGA, LISTO (plus PARIDAD when the macro is defined). All outputs are registered except ocupado, which is decoded from state.
- ESPERA:
  - inicio=1 at a posedge -> CARGA; cnt<=0; sr<=0; dir_r<=dir; err_paridad<=0.
  - enb is ignored.
- CARGA, on each posedge with enb=1:
  - dir_r=0: sr<={sr[N-2:0],s_in}.
  - dir_r=1: sr<={s_in,sr[N-1:1]}.
  - cnt<=cnt+1.
- CARGA, completion:
  - When cnt==N-1 and enb=1: q<=the shifted value; q_valid<=1; go to LISTO.
  - q_valid is visible right after the edge that captures the Nth bit (latency 0 cycles after the last bit).
- CARGA, other rules:
  - enb=0 holds sr and cnt indefinitely.
  - inicio and dir changes are ignored mid-frame.
- LISTO:
  - q and q_valid are held stable until ack=1 at a posedge; then q_valid<=0.
  - ack=1 and inicio=1 on the same edge -> CARGA directly (back-to-back frame; same initialisation as from ESPERA).
  - ack=1 with inicio=0 -> ESPERA.
  - enb=1 on an edge without ack: the bit is discarded and desborde<=1. desborde stays set until reset.
  - enb=1 on the same edge as ack: the bit is discarded, no overrun.
- ack outside LISTO has no effect.
- cnt width is clog2(N)+1; it is never compared past N.

Optional Feature:
Macro RECEPTOR_PARIDAD_EN.
- Defined:
  - After the Nth data bit, CARGA goes to PARIDAD instead of LISTO; q is not yet updated.
  - The next enb=1 bit is the parity bit p. On that edge: q<=sr; q_valid<=1; err_paridad<=(^sr)^p (even parity, 0 = ok); go to LISTO.
  - err_paridad clears at the next frame start.
- Not defined: the PARIDAD state does not exist, and err_paridad is constant 0.

Test Plan:
1. Reset, then inicio, dir=0, bits 1,0,1,1 on consecutive enb edges -> q=4'b1011; q_valid rises after the 4th bit; ocupado=1 from the first edge after inicio until ack.
2. dir=1, same bit sequence 1,0,1,1 -> q=4'b1101; then toggle dir mid-frame in a second frame -> no effect on the result.
3. Bits 0,1,1,0 with enb=0 gaps of 3 cycles between bits -> q=4'b0110 and completion only on the 4th enb edge; assert reset after bit 2 of a new frame -> all outputs return to 0 and the state returns to ESPERA.
4. After a frame completes, hold ack=0 and pulse enb with s_in=1 -> desborde=1 and q unchanged; then ack=1 -> q_valid=0, desborde stays 1.
5. In LISTO, ack=1 and inicio=1 on the same edge, then 4 bits 0,0,0,1 (dir=0) -> q_valid is low for exactly 4 cycles, then q=4'b0001.
6. With RECEPTOR_PARIDAD_EN: data 1011 + p=1 -> err_paridad=0; data 1011 + p=0 -> err_paridad=1; q=4'b1011 in both cases, with q_valid rising after the parity bit.
